regfile_param: RTL

Parametrised, resettable register file; successor to the 32x32 two-read/one-write register file in the datapath. Adds configurable data width, address width and read-port count, a hardwired-zero register 0 option, and a synchronous clear engine that zeroes every entry after reset or on request. Writes on the rising edge. A write-through bypass keeps the same-cycle write-then-read visibility that the decode stage relies on.

---
 rtl/regfile_param_if.sv | 33 +++
 rtl/regfile_param.sv | 133 +++++++++++++
 2 files changed

// File: rtl/regfile_param_if.sv
// Register file access bus.
//   ClearReq      : request a full re-zero of the array (master -> slave)
//   ReadRegister  : packed read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   ReadData      : packed combinational read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   WriteRegister : write address
//   WriteData     : write data
//   RegWrite      : write enable
//   Ready         : array valid, writes accepted (slave -> master)
//   Busy          : clear sequence in progress (slave -> master)
interface regfile_param_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NUM_READ   = 2
);
    logic                             ClearReq;
    logic [NUM_READ*ADDR_WIDTH-1:0]   ReadRegister;
    logic [NUM_READ*DATA_WIDTH-1:0]   ReadData;
    logic [ADDR_WIDTH-1:0]            WriteRegister;
    logic [DATA_WIDTH-1:0]            WriteData;
    logic                             RegWrite;
    logic                             Ready;
    logic                             Busy;

    modport master (
        output ClearReq, ReadRegister, WriteRegister, WriteData, RegWrite,
        input  ReadData, Ready, Busy
    );

    modport slave (
        input  ClearReq, ReadRegister, WriteRegister, WriteData, RegWrite,
        output ReadData, Ready, Busy
    );
endinterface

// File: rtl/regfile_param.sv
// Parametrised register file with a synchronous clear engine.
//   Clk   : clock, all state updates on the rising edge
//   Reset : synchronous active-high reset; restarts the clear sequence
//   bus   : regfile_param_if slave port (reads, write, clear request, Ready/Busy)
// NUM_READ combinational read ports with write-through bypass; optional
// hardwired-zero register 0. Contents are undefined until a clear completes,
// so reads return 0 while Ready is low.
module regfile_param #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NUM_READ   = 2,
    parameter bit          ZERO_REG   = 1'b1
) (
    input  logic             Clk,
    input  logic             Reset,
    regfile_param_if.slave   bus
);

    localparam int unsigned DEPTH   = 1 << ADDR_WIDTH;
    localparam int unsigned IDX_W   = ADDR_WIDTH + 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        clear_idx_q, clear_idx_d;
    logic                    ready_q, ready_d;
    logic                    busy_q, busy_d;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic                    mem_we_c;
    logic [ADDR_WIDTH-1:0]   mem_waddr_c;
    logic [DATA_WIDTH-1:0]   mem_wdata_c;

    logic                    wr_accept_c;
    logic [NUM_READ*DATA_WIDTH-1:0] rdata_c;

    // A user write lands this edge; also qualifies the read bypass.
    always_comb begin
        wr_accept_c = (state_q == ST_READY) && !Reset && bus.RegWrite && !bus.ClearReq
                      && !(ZERO_REG && (bus.WriteRegister == '0));
    end

    // Next-state, clear engine and array write port.
    always_comb begin
        state_d     = state_q;
        clear_idx_d = clear_idx_q;
        ready_d     = ready_q;
        busy_d      = busy_q;
        mem_we_c    = 1'b0;
        mem_waddr_c = bus.WriteRegister;
        mem_wdata_c = bus.WriteData;

        if (!Reset) begin
            case (state_q)
                ST_CLEAR: begin
                    mem_we_c    = 1'b1;
                    mem_waddr_c = clear_idx_q[ADDR_WIDTH-1:0];
                    mem_wdata_c = '0;
                    clear_idx_d = clear_idx_q + IDX_W'(1);
                    if (clear_idx_q == IDX_W'(DEPTH - 1)) begin
                        state_d = ST_READY;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
                ST_READY: begin
                    if (bus.ClearReq) begin
                        state_d     = ST_CLEAR;
                        clear_idx_d = '0;
                        ready_d     = 1'b0;
                        busy_d      = 1'b1;
                    end else begin
                        mem_we_c = wr_accept_c;
                    end
                end
                default: begin
                    state_d     = ST_CLEAR;
                    clear_idx_d = '0;
                    ready_d     = 1'b0;
                    busy_d      = 1'b1;
                end
            endcase
        end
    end

    // Control state; reset restarts the clear from index 0.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_CLEAR;
            clear_idx_q <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            clear_idx_q <= clear_idx_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
        end
    end

    // Storage array; deliberately not reset, the clear engine zeroes it.
    always_ff @(posedge Clk) begin
        if (mem_we_c) begin
            mem_q[mem_waddr_c] <= mem_wdata_c;
        end
    end

    // Read ports: not-ready, zero register, bypass, then array.
    always_comb begin
        rdata_c = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            if (!ready_q) begin
                rdata_c[i*DATA_WIDTH +: DATA_WIDTH] = '0;
            end else if (ZERO_REG && (bus.ReadRegister[i*ADDR_WIDTH +: ADDR_WIDTH] == '0)) begin
                rdata_c[i*DATA_WIDTH +: DATA_WIDTH] = '0;
            end else if (wr_accept_c
                         && (bus.WriteRegister == bus.ReadRegister[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                rdata_c[i*DATA_WIDTH +: DATA_WIDTH] = bus.WriteData;
            end else begin
                rdata_c[i*DATA_WIDTH +: DATA_WIDTH] =
                    mem_q[bus.ReadRegister[i*ADDR_WIDTH +: ADDR_WIDTH]];
            end
        end
    end

    assign bus.ReadData = rdata_c;
    assign bus.Ready    = ready_q;
    assign bus.Busy     = busy_q;

endmodule
